// File: rtl/opcode_prefetch.sv
// rtl/opcode_prefetch.sv - byte-wide opcode prefetch queue with redirect flush
// Optional feature macro: OPCODE_PREFETCH_BYPASS_EN (ack-to-decode bypass when the queue is empty)
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   mem_req_o, mem_addr_o      single-outstanding fetch request and its address
//   mem_ack_i, mem_data_i      fetch completion and the fetched byte (same cycle)
//   redirect_i, redirect_addr_i flush the queue and restart fetch at a new address
//   op_valid_o, op_o, op_pc_o  oldest queued byte and its fetch address
//   op_ready_i                 decode accepts the presented byte
//   level_o                    number of occupied queue entries
module opcode_prefetch #(
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  output logic                      mem_req_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  input  logic                      mem_ack_i,
  input  logic [7:0]                mem_data_i,
  input  logic                      redirect_i,
  input  logic [ADDR_W-1:0]         redirect_addr_i,
  output logic                      op_valid_o,
  output logic [7:0]                op_o,
  output logic [ADDR_W-1:0]         op_pc_o,
  input  logic                      op_ready_i,
  output logic [$clog2(DEPTH):0]    level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [LVL_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic                valid_q, valid_d;
  logic [7:0]          op_q, op_d;
  logic [ADDR_W-1:0]   op_pc_q, op_pc_d;
  logic [7:0]          data_mem_q [DEPTH];
  logic [ADDR_W-1:0]   pc_mem_q   [DEPTH];

  logic                acc;
  logic                byp_show;
  logic                byp_take;
  logic                push;
  logic                pop;
  logic [LVL_W-1:0]    level_after;
  logic                space;

  always_comb begin
    // An ack is accepted only in REQ and only if no redirect kills it this cycle.
    acc = (state_q == S_REQ) && mem_ack_i && !redirect_i;
`ifdef OPCODE_PREFETCH_BYPASS_EN
    byp_show = acc && (count_q == '0);
`else
    byp_show = 1'b0;
`endif
    // A bypassed byte taken by decode never enters the queue.
    byp_take    = byp_show && op_ready_i;
    push        = acc && !byp_take;
    pop         = valid_q && op_ready_i && !redirect_i;
    level_after = count_q + LVL_W'(push) - LVL_W'(pop);
    space       = (level_after < LVL_W'(DEPTH));

    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_addr_i;
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      case (state_q)
        S_IDLE: begin
          state_d = S_REQ;
          req_d   = 1'b1;
          addr_d  = redirect_addr_i;
        end
        S_REQ, S_DRAIN: begin
          req_d = 1'b1;
          if (mem_ack_i) begin
            state_d = S_REQ;
            addr_d  = redirect_addr_i;
          end else begin
            // Outstanding request cannot be withdrawn; keep it up and drop its data later.
            state_d = S_DRAIN;
          end
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end else begin
      count_d = level_after;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case (state_q)
        S_IDLE: begin
          if (space) begin
            state_d = S_REQ;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
          end
        end
        S_REQ: begin
          if (acc) begin
            fetch_pc_d = addr_q + ADDR_W'(1);
            if (space) begin
              addr_d = addr_q + ADDR_W'(1);
            end else begin
              state_d = S_IDLE;
              req_d   = 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (mem_ack_i) begin
            state_d = S_REQ;
            addr_d  = fetch_pc_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end

    // Head registers track the entry at the post-update read pointer; if that
    // slot is being written this cycle the incoming byte is forwarded.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      op_d    = mem_data_i;
      op_pc_d = addr_q;
    end else begin
      op_d    = data_mem_q[rd_ptr_d];
      op_pc_d = pc_mem_q[rd_ptr_d];
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      valid_q    <= 1'b0;
      op_q       <= '0;
      op_pc_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      valid_q    <= valid_d;
      op_q       <= op_d;
      op_pc_q    <= op_pc_d;
      if (push) begin
        data_mem_q[wr_ptr_q] <= mem_data_i;
        pc_mem_q[wr_ptr_q]   <= addr_q;
      end
    end
  end

  assign mem_req_o  = req_q;
  assign mem_addr_o = addr_q;
  assign level_o    = count_q;
  assign op_valid_o = valid_q | byp_show;
  assign op_o       = byp_show ? mem_data_i : op_q;
  assign op_pc_o    = byp_show ? addr_q : op_pc_q;

endmodule
